// File: rtl/cache_arbiter.sv
// Arbitrates icache line fills and dcache fills/writebacks onto one 4-beat, 64-bit memory port.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both caches are pending.
module cache_arbiter #(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t         state_q, state_d;
  owner_t         owner_q, owner_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   line_q, line_d;
  logic           grant_d_side;
  logic [7:0]     beat_base;
  logic           unused_addr_bits;

`ifdef ARB_ROUND_ROBIN_EN
  // Side served by the most recent completed grant; reset value makes dcache win first.
  owner_t         last_q, last_d;
`endif

  // Line-offset bits are cleared on grant, so they never reach any logic.
  assign unused_addr_bits = ^{i_address[4:0], d_address[4:0]};

  assign beat_base = {cnt_q, 6'b0};

`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d_side = (d_read | d_write) & (~i_read | (last_q == OWN_I));
`else
  assign grant_d_side = d_read | d_write;
`endif

  // NOTE: every combinational output and next-state gets a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    line_d    = line_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_d_side) begin
          owner_d = OWN_D;
          addr_d  = {d_address[31:5], 5'b0};
          line_d  = '0;
          cnt_d   = '0;
          if (d_write) begin
            state_d = D_WRITE;
            wdata_d = d_wdata;
          end else begin
            state_d = D_READ;
          end
        end else if (i_read) begin
          owner_d = OWN_I;
          addr_d  = {i_address[31:5], 5'b0};
          line_d  = '0;
          cnt_d   = '0;
          state_d = I_READ;
        end
      end

      I_READ, D_READ: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          line_d[beat_base +: 64] = mem_rdata;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      D_WRITE: begin
        mem_write = 1'b1;
        if (mem_resp) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      DONE: begin
        i_resp  = (owner_q == OWN_I);
        d_resp  = (owner_q == OWN_D);
        state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = owner_q;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      cnt_q   <= '0;
      addr_q  <= '0;
      // NOTE: the line and write buffers are plain registers, not a RAM, so they are
      // reset to keep returned data and mem_wdata deterministic after reset.
      wdata_q <= '0;
      line_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata   = (state_q == D_WRITE) ? wdata_q[beat_base +: 64] : 64'd0;
  // Returned line stays visible to its owner until the next grant clears the buffer.
  assign i_rdata     = (owner_q == OWN_I) ? line_q : '0;
  assign d_rdata     = (owner_q == OWN_D) ? line_q : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] LINE1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINEW = {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
                                    64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
  localparam logic [255:0] LINEI = {64'h0101_0101_0000_0004, 64'h0101_0101_0000_0003,
                                    64'h0101_0101_0000_0002, 64'h0101_0101_0000_0001};
  localparam logic [255:0] LINED = {64'h0D0D_0D0D_0000_0004, 64'h0D0D_0D0D_0000_0003,
                                    64'h0D0D_0D0D_0000_0002, 64'h0D0D_0D0D_0000_0001};
  localparam logic [255:0] LINES = {64'h5A5A_0000_0000_0004, 64'hA5A5_0000_0000_0003,
                                    64'h5A5A_0000_0000_0002, 64'hA5A5_0000_0000_0001};

  cache_arbiter #(.BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in the first transfer cycle; leaves the bench in the DONE cycle.
  task automatic run_beats(input bit is_write, input logic [255:0] line, input int stall,
                           input logic [31:0] exp_addr);
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < stall; s++) begin
        mem_resp = 1'b0;
        check("stall_mem_read", mem_read, !is_write);
        check("stall_mem_write", mem_write, is_write);
        check("stall_addr", mem_address, exp_addr);
        if (is_write) check("stall_wdata", mem_wdata, line[k*64 +: 64]);
        tick();
      end
      mem_resp  = 1'b1;
      mem_rdata = line[k*64 +: 64];
      check("beat_mem_read", mem_read, !is_write);
      check("beat_mem_write", mem_write, is_write);
      check("beat_addr", mem_address, exp_addr);
      if (is_write) check("beat_wdata", mem_wdata, line[k*64 +: 64]);
      tick();
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
    check("done_mem_read_low", mem_read, 1'b0);
    check("done_mem_write_low", mem_write, 1'b0);
  endtask

  // Both caches request together; d_first selects which side must be served first.
  task automatic pair(input bit d_first);
    i_read = 1'b1; i_address = 32'h0000_0104;
    d_read = 1'b1; d_address = 32'h0000_021F;
    check("pair_idle_noreq", {mem_read, mem_write}, 2'b00);
    tick();
    if (d_first) begin
      run_beats(1'b0, LINED, 0, 32'h0000_0200);
      check("pair1_d_resp", d_resp, 1'b1);
      check("pair1_i_resp", i_resp, 1'b0);
      check("pair1_d_rdata", d_rdata, LINED);
      d_read = 1'b0;
      tick();
      check("pair_gap_idle", mem_read, 1'b0);
      tick();
      run_beats(1'b0, LINEI, 0, 32'h0000_0100);
      check("pair2_i_resp", i_resp, 1'b1);
      check("pair2_d_resp", d_resp, 1'b0);
      check("pair2_i_rdata", i_rdata, LINEI);
      i_read = 1'b0;
    end else begin
      run_beats(1'b0, LINEI, 0, 32'h0000_0100);
      check("pair1_i_resp", i_resp, 1'b1);
      check("pair1_d_resp", d_resp, 1'b0);
      check("pair1_i_rdata", i_rdata, LINEI);
      i_read = 1'b0;
      tick();
      check("pair_gap_idle", mem_read, 1'b0);
      tick();
      run_beats(1'b0, LINED, 0, 32'h0000_0200);
      check("pair2_d_resp", d_resp, 1'b1);
      check("pair2_i_resp", i_resp, 1'b0);
      check("pair2_d_rdata", d_rdata, LINED);
      d_read = 1'b0;
    end
    tick();
    check("pair_end_resp", {i_resp, d_resp}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    tick();
    tick();
    check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    check("rst_resp", {i_resp, d_resp}, 2'b00);
    check("rst_addr", mem_address, 32'h0);
    check("rst_wdata", mem_wdata, 64'h0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    rst = 1'b0;

    // Simultaneous pair straight after reset: dcache first in both builds.
    pair(1'b1);

    // Writeback alone.
    d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = LINEW;
    tick();
    run_beats(1'b1, LINEW, 0, 32'h8000_0040);
    check("wr_d_resp", d_resp, 1'b1);
    check("wr_i_resp", i_resp, 1'b0);
    d_write = 1'b0; d_wdata = '0;
    tick();
    check("wr_d_resp_pulse", d_resp, 1'b0);
    check("wr_i_resp_after", i_resp, 1'b0);

    // Second pair after a dcache grant: round-robin hands it to the icache.
`ifdef ARB_ROUND_ROBIN_EN
    pair(1'b0);
`else
    pair(1'b1);
`endif

    // Icache fill with mem_resp left high through DONE and the following IDLE.
    i_read = 1'b1; i_address = 32'h0000_1234;
    tick();
    run_beats(1'b0, LINE1, 0, 32'h0000_1220);
    check("i_resp_cycle6", i_resp, 1'b1);
    check("i_d_resp", d_resp, 1'b0);
    check("i_rdata", i_rdata, LINE1);
    i_read = 1'b0;
    mem_resp = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    check("i_resp_pulse", i_resp, 1'b0);
    check("idle_ignores_resp", {mem_read, mem_write}, 2'b00);
    check("i_rdata_held", i_rdata, LINE1);
    tick();
    check("i_rdata_held2", i_rdata, LINE1);
    mem_resp = 1'b0; mem_rdata = '0;

    // Dcache fill with three stall cycles before every beat.
    d_read = 1'b1; d_address = 32'h0000_ABCD;
    tick();
    run_beats(1'b0, LINES, 3, 32'h0000_ABC0);
    check("stall_d_resp", d_resp, 1'b1);
    check("stall_d_rdata", d_rdata, LINES);
    d_read = 1'b0;
    tick();

    // Reset after two beats of a dcache fill.
    d_read = 1'b1; d_address = 32'h0000_0300;
    tick();
    check("rst_mid_mem_read", mem_read, 1'b1);
    mem_resp = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
    tick();
    tick();
    rst = 1'b1; mem_resp = 1'b0; d_read = 1'b0;
    tick();
    check("rst_mid_read_low", mem_read, 1'b0);
    check("rst_mid_no_resp", d_resp, 1'b0);
    check("rst_mid_d_rdata", d_rdata, '0);
    rst = 1'b0;
    tick();
    check("rst_mid_no_resp2", {i_resp, d_resp}, 2'b00);

    i_read = 1'b1; i_address = 32'h0000_1234;
    tick();
    run_beats(1'b0, LINE1, 0, 32'h0000_1220);
    check("post_rst_i_resp", i_resp, 1'b1);
    check("post_rst_i_rdata", i_rdata, LINE1);
    i_read = 1'b0;
    tick();
    check("post_rst_resp_low", i_resp, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
